multicycle_controller: RTL and testbench

Main control FSM sequencing a multi-cycle MIPS-subset datapath that shares one memory port between instruction fetch and data access. It decodes opcode/funct from the instruction register and issues per-cycle enables, mux selects and ALU control to the datapath, stalling on a memory-ready handshake. It also flags illegal instructions and drives the stdout write strobe.

---
 rtl/multicycle_controller.sv | 172 +++++++++++++++++
 tb/tb_multicycle_controller.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Main control FSM for a multi-cycle MIPS-subset datapath sharing one memory port.
// Outputs are decoded combinationally from state; memory states stall on i_mem_ready.
module multicycle_controller #(
  parameter logic [3:0] ADD_CTRL   = 4'b0010,
  parameter logic [3:0] SUB_CTRL   = 4'b0110,
  parameter logic [5:0] OUT_OPCODE = 6'h3F
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  input  logic       i_zero,
  input  logic       i_mem_ready,
  output logic       o_memread,
  output logic       o_memwrite,
  output logic       o_iord,
  output logic       o_irwrite,
  output logic       o_pcen,
  output logic       o_regwrite,
  output logic       o_regdst,
  output logic       o_memtoreg,
  output logic       o_alusrca,
  output logic [1:0] o_alusrcb,
  output logic [1:0] o_pcsrc,
  output logic [3:0] o_aluctrl,
  output logic       o_outwrite,
  output logic       o_illegal,
  output logic [3:0] o_state
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTEX    = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11,
    S_OUTPUT  = 4'd12,
    S_ILLEGAL = 4'd15
  } state_t;

  state_t     r_state;
  logic       w_funct_legal;
  logic [3:0] w_funct_ctrl;

  always_comb begin
    w_funct_legal = 1'b1;
    w_funct_ctrl  = ADD_CTRL;
    case (i_funct)
      6'h20:   w_funct_ctrl = ADD_CTRL;
      6'h22:   w_funct_ctrl = SUB_CTRL;
      6'h24:   w_funct_ctrl = 4'b0000;
      6'h25:   w_funct_ctrl = 4'b0001;
      6'h2A:   w_funct_ctrl = 4'b0111;
      default: w_funct_legal = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state <= S_FETCH;
    end else begin
      case (r_state)
        S_FETCH:  if (i_mem_ready) r_state <= S_DECODE;
        S_DECODE: begin
          if (i_opcode == 6'h00)
            r_state <= w_funct_legal ? S_RTEX : S_ILLEGAL;
          else if (i_opcode == 6'h23 || i_opcode == 6'h2B)
            r_state <= S_MEMADR;
          else if (i_opcode == 6'h04)
            r_state <= S_BRANCH;
          else if (i_opcode == 6'h08)
            r_state <= S_ADDIEX;
          else if (i_opcode == 6'h02)
            r_state <= S_JUMP;
          else if (i_opcode == OUT_OPCODE)
            r_state <= S_OUTPUT;
          else
            r_state <= S_ILLEGAL;
        end
        S_MEMADR: r_state <= (i_opcode == 6'h23) ? S_MEMRD : S_MEMWR;
        S_MEMRD:  if (i_mem_ready) r_state <= S_MEMWB;
        S_MEMWR:  if (i_mem_ready) r_state <= S_FETCH;
        S_RTEX:   r_state <= S_ALUWB;
        S_ADDIEX: r_state <= S_ADDIWB;
        S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP, S_OUTPUT:
                  r_state <= S_FETCH;
        default:  r_state <= S_ILLEGAL;
      endcase
    end
  end

  // Reset gates every output combinationally so no strobe leaks on the reset cycle.
  always_comb begin
    o_memread  = 1'b0;
    o_memwrite = 1'b0;
    o_iord     = 1'b0;
    o_irwrite  = 1'b0;
    o_pcen     = 1'b0;
    o_regwrite = 1'b0;
    o_regdst   = 1'b0;
    o_memtoreg = 1'b0;
    o_alusrca  = 1'b0;
    o_alusrcb  = 2'b00;
    o_pcsrc    = 2'b00;
    o_aluctrl  = ADD_CTRL;
    o_outwrite = 1'b0;
    o_illegal  = 1'b0;
    if (i_reset) begin
      case (r_state)
        S_FETCH: begin
          o_memread = 1'b1;
          o_alusrcb = 2'b01;
          o_irwrite = i_mem_ready;
          o_pcen    = i_mem_ready;
        end
        S_DECODE: o_alusrcb = 2'b11;
        S_MEMADR: begin
          o_alusrca = 1'b1;
          o_alusrcb = 2'b10;
        end
        S_MEMRD: begin
          o_memread = 1'b1;
          o_iord    = 1'b1;
        end
        S_MEMWB: begin
          o_regwrite = 1'b1;
          o_memtoreg = 1'b1;
        end
        S_MEMWR: begin
          o_memwrite = 1'b1;
          o_iord     = 1'b1;
        end
        S_RTEX: begin
          o_alusrca = 1'b1;
          o_aluctrl = w_funct_ctrl;
        end
        S_ALUWB: begin
          o_regwrite = 1'b1;
          o_regdst   = 1'b1;
        end
        S_BRANCH: begin
          o_alusrca = 1'b1;
          o_aluctrl = SUB_CTRL;
          o_pcsrc   = 2'b01;
          o_pcen    = i_zero;
        end
        S_ADDIEX: begin
          o_alusrca = 1'b1;
          o_alusrcb = 2'b10;
        end
        S_ADDIWB: o_regwrite = 1'b1;
        S_JUMP: begin
          o_pcsrc = 2'b10;
          o_pcen  = 1'b1;
        end
        S_OUTPUT:  o_outwrite = 1'b1;
        S_ILLEGAL: o_illegal  = 1'b1;
        default:   o_illegal  = 1'b1;
      endcase
    end
  end

  assign o_state = r_state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: inputs change on the falling edge,
// outputs are checked 1 time unit later, state advances on the rising edge.
module tb_multicycle_controller;

  logic       i_clk;
  logic       i_reset;
  logic [5:0] i_opcode;
  logic [5:0] i_funct;
  logic       i_zero;
  logic       i_mem_ready;
  logic       o_memread, o_memwrite, o_iord, o_irwrite, o_pcen, o_regwrite;
  logic       o_regdst, o_memtoreg, o_alusrca, o_outwrite, o_illegal;
  logic [1:0] o_alusrcb, o_pcsrc;
  logic [3:0] o_aluctrl, o_state;

  int n_chk;
  int n_pass;

  multicycle_controller dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_opcode(i_opcode), .i_funct(i_funct),
    .i_zero(i_zero), .i_mem_ready(i_mem_ready),
    .o_memread(o_memread), .o_memwrite(o_memwrite), .o_iord(o_iord),
    .o_irwrite(o_irwrite), .o_pcen(o_pcen), .o_regwrite(o_regwrite),
    .o_regdst(o_regdst), .o_memtoreg(o_memtoreg), .o_alusrca(o_alusrca),
    .o_alusrcb(o_alusrcb), .o_pcsrc(o_pcsrc), .o_aluctrl(o_aluctrl),
    .o_outwrite(o_outwrite), .o_illegal(o_illegal), .o_state(o_state)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic test_reset();
    i_reset = 1'b0; i_mem_ready = 1'b1; i_opcode = 6'h23; i_funct = 6'h00; i_zero = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge i_clk);
      #1;
      n_chk++;
      if (o_state !== 4'd0) $display("FAIL reset_state[%0d] got %0d want 0", c, o_state);
      else n_pass++;
      n_chk++;
      if ({o_memread, o_memwrite, o_irwrite, o_pcen, o_regwrite, o_outwrite, o_illegal} !== 7'b0)
        $display("FAIL reset_enables[%0d] got %b want 0000000", c,
                 {o_memread, o_memwrite, o_irwrite, o_pcen, o_regwrite, o_outwrite, o_illegal});
      else n_pass++;
      n_chk++;
      if (o_aluctrl !== 4'b0010 || o_alusrcb !== 2'b00 || o_pcsrc !== 2'b00)
        $display("FAIL reset_selects got aluctrl=%b alusrcb=%b pcsrc=%b want 0010/00/00",
                 o_aluctrl, o_alusrcb, o_pcsrc);
      else n_pass++;
    end
    @(negedge i_clk);
    i_reset = 1'b1;
    #1;
    n_chk++;
    if ({o_memread, o_irwrite, o_pcen, o_alusrcb} !== 5'b11101)
      $display("FAIL release_fetch got rd/ir/pcen/srcb=%b want 11101",
               {o_memread, o_irwrite, o_pcen, o_alusrcb});
    else n_pass++;
  endtask

  // FETCH stall, then jump
  task automatic test_jump_stall();
    logic [3:0] exp [5];
    exp = '{4'd0, 4'd0, 4'd1, 4'd11, 4'd0};
    i_opcode = 6'h02;
    for (int i = 0; i < 5; i++) begin
      i_mem_ready = (i == 0) ? 1'b0 : 1'b1;
      #1;
      n_chk++;
      if (o_state !== exp[i]) $display("FAIL jump_state[%0d] got %0d want %0d", i, o_state, exp[i]);
      else n_pass++;
      if (i == 0) begin
        n_chk++;
        if (o_irwrite !== 1'b0 || o_pcen !== 1'b0 || o_memread !== 1'b1)
          $display("FAIL fetch_stall got ir=%b pcen=%b rd=%b want 0 0 1", o_irwrite, o_pcen, o_memread);
        else n_pass++;
      end
      if (i == 3) begin
        n_chk++;
        if (o_pcen !== 1'b1 || o_pcsrc !== 2'b10)
          $display("FAIL jump_pc got pcen=%b pcsrc=%b want 1 10", o_pcen, o_pcsrc);
        else n_pass++;
      end
      if (i < 4) @(negedge i_clk);
    end
  endtask

  task automatic test_add();
    logic [3:0] exp [5];
    exp = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
    i_opcode = 6'h00; i_funct = 6'h20; i_mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_chk++;
      if (o_state !== exp[i]) $display("FAIL add_state[%0d] got %0d want %0d", i, o_state, exp[i]);
      else n_pass++;
      n_chk++;
      if (o_regwrite !== (i == 3) || o_regdst !== (i == 3))
        $display("FAIL add_wb[%0d] got regwrite=%b regdst=%b want %b", i, o_regwrite, o_regdst, i == 3);
      else n_pass++;
      if (i == 2) begin
        n_chk++;
        if (o_aluctrl !== 4'b0010 || o_alusrca !== 1'b1 || o_alusrcb !== 2'b00)
          $display("FAIL add_ex got aluctrl=%b srca=%b srcb=%b want 0010 1 00", o_aluctrl, o_alusrca, o_alusrcb);
        else n_pass++;
      end
      if (i < 4) @(negedge i_clk);
    end
  endtask

  task automatic test_rtype_alu();
    logic [5:0] fn [4];
    logic [3:0] ctl [4];
    fn  = '{6'h22, 6'h24, 6'h25, 6'h2A};
    ctl = '{4'b0110, 4'b0000, 4'b0001, 4'b0111};
    i_opcode = 6'h00; i_mem_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      i_funct = fn[k];
      @(negedge i_clk); @(negedge i_clk);
      #1;
      n_chk++;
      if (o_state !== 4'd6 || o_aluctrl !== ctl[k])
        $display("FAIL rtype_ctrl[%0d] got state=%0d aluctrl=%b want 6 %b", k, o_state, o_aluctrl, ctl[k]);
      else n_pass++;
      @(negedge i_clk); @(negedge i_clk);
    end
  endtask

  task automatic test_lw();
    logic [3:0] exp [8];
    exp = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd4, 4'd0};
    i_opcode = 6'h23;
    for (int i = 0; i < 8; i++) begin
      i_mem_ready = (i == 3 || i == 4) ? 1'b0 : 1'b1;
      #1;
      n_chk++;
      if (o_state !== exp[i]) $display("FAIL lw_state[%0d] got %0d want %0d", i, o_state, exp[i]);
      else n_pass++;
      n_chk++;
      if (o_regwrite !== (i == 6) || o_memtoreg !== (i == 6))
        $display("FAIL lw_wb[%0d] got regwrite=%b memtoreg=%b want %b", i, o_regwrite, o_memtoreg, i == 6);
      else n_pass++;
      if (i >= 3 && i <= 5) begin
        n_chk++;
        if (o_memread !== 1'b1 || o_iord !== 1'b1)
          $display("FAIL lw_rd[%0d] got memread=%b iord=%b want 1 1", i, o_memread, o_iord);
        else n_pass++;
      end
      if (i < 7) @(negedge i_clk);
    end
  endtask

  task automatic test_beq();
    logic [3:0] exp [4];
    exp = '{4'd0, 4'd1, 4'd8, 4'd0};
    i_opcode = 6'h04; i_mem_ready = 1'b1;
    for (int z = 1; z >= 0; z--) begin
      i_zero = z[0];
      for (int i = 0; i < 4; i++) begin
        #1;
        n_chk++;
        if (o_state !== exp[i]) $display("FAIL beq%0d_state[%0d] got %0d want %0d", z, i, o_state, exp[i]);
        else n_pass++;
        if (i == 2) begin
          n_chk++;
          if (o_pcen !== z[0] || o_pcsrc !== 2'b01 || o_aluctrl !== 4'b0110)
            $display("FAIL beq%0d_branch got pcen=%b pcsrc=%b aluctrl=%b want %b 01 0110",
                     z, o_pcen, o_pcsrc, o_aluctrl, z[0]);
          else n_pass++;
        end
        if (i < 3) @(negedge i_clk);
      end
    end
    i_zero = 1'b0;
  endtask

  task automatic test_sw();
    logic [3:0] exp [6];
    exp = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd0};
    i_opcode = 6'h2B;
    for (int i = 0; i < 6; i++) begin
      i_mem_ready = (i == 3) ? 1'b0 : 1'b1;
      #1;
      n_chk++;
      if (o_state !== exp[i]) $display("FAIL sw_state[%0d] got %0d want %0d", i, o_state, exp[i]);
      else n_pass++;
      n_chk++;
      if (o_memwrite !== (i == 3 || i == 4) || o_iord !== (i == 3 || i == 4))
        $display("FAIL sw_wr[%0d] got memwrite=%b iord=%b want %b", i, o_memwrite, o_iord, i == 3 || i == 4);
      else n_pass++;
      if (i < 5) @(negedge i_clk);
    end
  endtask

  task automatic test_addi_out();
    logic [3:0] exp [8];
    exp = '{4'd0, 4'd1, 4'd9, 4'd10, 4'd0, 4'd1, 4'd12, 4'd0};
    i_mem_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      i_opcode = (i < 4) ? 6'h08 : 6'h3F;
      #1;
      n_chk++;
      if (o_state !== exp[i]) $display("FAIL addi_out_state[%0d] got %0d want %0d", i, o_state, exp[i]);
      else n_pass++;
      n_chk++;
      if (o_outwrite !== (i == 6) || o_regwrite !== (i == 3) || o_regdst !== 1'b0)
        $display("FAIL addi_out_en[%0d] got outwrite=%b regwrite=%b regdst=%b", i, o_outwrite, o_regwrite, o_regdst);
      else n_pass++;
      if (i == 2) begin
        n_chk++;
        if (o_alusrca !== 1'b1 || o_alusrcb !== 2'b10 || o_aluctrl !== 4'b0010)
          $display("FAIL addi_ex got srca=%b srcb=%b aluctrl=%b want 1 10 0010", o_alusrca, o_alusrcb, o_aluctrl);
        else n_pass++;
      end
      if (i < 7) @(negedge i_clk);
    end
  endtask

  task automatic test_reset_abort();
    i_opcode = 6'h2B; i_mem_ready = 1'b1;
    repeat (3) @(negedge i_clk);
    i_mem_ready = 1'b0;
    #1;
    n_chk++;
    if (o_state !== 4'd5 || o_memwrite !== 1'b1)
      $display("FAIL abort_pre got state=%0d memwrite=%b want 5 1", o_state, o_memwrite);
    else n_pass++;
    i_reset = 1'b0;
    #1;
    n_chk++;
    if (o_memwrite !== 1'b0 || o_iord !== 1'b0)
      $display("FAIL abort_strobe got memwrite=%b iord=%b want 0 0", o_memwrite, o_iord);
    else n_pass++;
    @(negedge i_clk);
    #1;
    n_chk++;
    if (o_state !== 4'd0) $display("FAIL abort_state got %0d want 0", o_state);
    else n_pass++;
    i_reset = 1'b1; i_mem_ready = 1'b1;
  endtask

  task automatic test_illegal();
    logic [5:0] op [2];
    logic [5:0] fn [2];
    op = '{6'h11, 6'h00};
    fn = '{6'h00, 6'h03};
    for (int k = 0; k < 2; k++) begin
      i_opcode = op[k]; i_funct = fn[k];
      for (int i = 0; i < 6; i++) begin
        i_mem_ready = (i < 2) ? 1'b1 : i[0];
        i_zero = 1'b1;
        #1;
        n_chk++;
        if (o_state !== ((i < 2) ? i[3:0] : 4'd15))
          $display("FAIL ill%0d_state[%0d] got %0d want %0d", k, i, o_state, (i < 2) ? i : 15);
        else n_pass++;
        if (i >= 2) begin
          n_chk++;
          if (o_illegal !== 1'b1 ||
              {o_memread, o_memwrite, o_irwrite, o_pcen, o_regwrite, o_outwrite} !== 6'b0)
            $display("FAIL ill%0d_out[%0d] got illegal=%b enables=%b want 1 000000", k, i, o_illegal,
                     {o_memread, o_memwrite, o_irwrite, o_pcen, o_regwrite, o_outwrite});
          else n_pass++;
        end
        if (i < 5) @(negedge i_clk);
      end
      i_reset = 1'b0;
      #1;
      n_chk++;
      if (o_illegal !== 1'b0) $display("FAIL ill%0d_clear got illegal=%b want 0", k, o_illegal);
      else n_pass++;
      @(negedge i_clk);
      #1;
      n_chk++;
      if (o_state !== 4'd0) $display("FAIL ill%0d_reset_state got %0d want 0", k, o_state);
      else n_pass++;
      i_reset = 1'b1; i_zero = 1'b0; i_mem_ready = 1'b1;
    end
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    test_reset();
    test_jump_stall();
    test_add();
    test_rtype_alu();
    test_lw();
    test_beq();
    test_sw();
    test_addi_out();
    test_reset_abort();
    test_illegal();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
